// File: rtl/sa_pkg.sv
// sa_pkg: shared definitions for the systolic-array tile sequencer.
//   sa_state_e  : sequencer state encoding (IDLE, RUN, DRAIN, CAPT, DONE)
//   KW, TW, DW  : counter widths for the default array configuration
//   drain_len() : number of zero-fed fire cycles needed to flush the skew
package sa_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        CAPT  = 3'd3,
        DONE  = 3'd4
    } sa_state_e;

    localparam int SA_ROWS     = 8;
    localparam int SA_COLS     = 8;
    localparam int SA_MAXK     = 256;
    localparam int SA_MAXTILES = 1024;
    localparam int SA_PE_LAT   = 1;

    localparam int KW = $clog2(SA_MAXK + 1);
    localparam int TW = $clog2(SA_MAXTILES + 1);
    localparam int DW = $clog2(SA_ROWS + SA_COLS + SA_PE_LAT);

    // Skew across the array plus the PE pipeline depth.
    function automatic int drain_len(input int rows, input int cols, input int pe_lat);
        return rows + cols - 2 + pe_lat;
    endfunction

endpackage

// File: rtl/sa_op_counter.sv
// sa_op_counter: loadable up-counter with enable and terminal compare.
//   clk, rstn : clock, async active-low reset
//   load      : load load_val (priority over en)
//   en        : increment by one
//   cmp       : terminal compare value
//   term      : count equals cmp
//   at_zero   : count equals zero
module sa_op_counter
    import sa_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] cmp,
    output logic         term,
    output logic         at_zero
);

    logic [W-1:0] cnt_r;

    // Count register; load wins over enable.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en) begin
            cnt_r <= cnt_r + W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign term    = (cnt_r == cmp);
    assign at_zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/sa_core_seq.sv
// sa_core_seq: tile sequencer for a ROWS x COLS output-stationary systolic array.
//   start/cfg_k/cfg_tiles : run request and its configuration
//   a_empty/w_empty       : per-lane input FIFO empty flags
//   out_full              : per-column output controllers cannot accept a capture
//   rd_en                 : pop all input FIFOs (combinational)
//   fire/zero_in/acc_clr  : PE array step, zero edge inputs, load instead of accumulate
//   capture               : column controllers latch the PE results
//   busy/done/err         : run status, end-of-run pulse, illegal-start pulse
//   stall_cnt             : saturating count of RUN cycles without a pop
module sa_core_seq
    import sa_pkg::*;
#(
    parameter int ROWS     = SA_ROWS,
    parameter int COLS     = SA_COLS,
    parameter int MAXK     = SA_MAXK,
    parameter int MAXTILES = SA_MAXTILES,
    parameter int PE_LAT   = SA_PE_LAT
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            start,
    input  logic [$clog2(MAXK+1)-1:0]       cfg_k,
    input  logic [$clog2(MAXTILES+1)-1:0]   cfg_tiles,
    input  logic [ROWS-1:0]                 a_empty,
    input  logic [COLS-1:0]                 w_empty,
    input  logic [COLS-1:0]                 out_full,
    output logic                            rd_en,
    output logic                            fire,
    output logic                            zero_in,
    output logic                            acc_clr,
    output logic                            capture,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic [31:0]                     stall_cnt
);

    localparam int CKW   = $clog2(MAXK + 1);
    localparam int CTW   = $clog2(MAXTILES + 1);
    localparam int CDW   = $clog2(ROWS + COLS + PE_LAT);
    localparam int D_LEN = drain_len(ROWS, COLS, PE_LAT);

    localparam logic [CKW-1:0] K_MAX  = CKW'(MAXK);
    localparam logic [CTW-1:0] T_MAX  = CTW'(MAXTILES);
    localparam logic [CKW-1:0] K_ONE  = CKW'(1);
    localparam logic [CTW-1:0] T_ONE  = CTW'(1);
    localparam logic [CDW-1:0] D_LAST = CDW'(D_LEN - 1);

    sa_state_e      state_r, next_state_s;
    logic [CKW-1:0] k_r;
    logic [CTW-1:0] tiles_r;
    logic [31:0]    stall_r;
    logic           fire_r, zero_in_r, acc_clr_r, capture_r, busy_r, done_r, err_r;

    logic cfg_ok_s, start_ok_s, rd_en_s, cap_s, err_s;
    logic beat_load_s, drain_load_s;
    logic beat_term_s, beat_zero_s, drain_term_s, tile_term_s;
    logic drain_zero_s, tile_zero_s;

    // Start qualification, pop decision and next-state selection.
    always_comb begin
        cfg_ok_s     = (cfg_k != {CKW{1'b0}}) && (cfg_k <= K_MAX) &&
                       (cfg_tiles != {CTW{1'b0}}) && (cfg_tiles <= T_MAX);
        start_ok_s   = start && (state_r == IDLE) && cfg_ok_s;
        rd_en_s      = (state_r == RUN) && !(|a_empty) && !(|w_empty);
        cap_s        = (state_r == CAPT) && !(|out_full);
        // A start in DONE is silently dropped; any other start while active is an error.
        err_s        = start && (((state_r == IDLE) && !cfg_ok_s) ||
                                 (state_r == RUN) || (state_r == DRAIN) || (state_r == CAPT));
        beat_load_s  = start_ok_s || (cap_s && !tile_term_s);
        drain_load_s = rd_en_s && beat_term_s;
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_ok_s) next_state_s = RUN;
                else            next_state_s = IDLE;
            end
            RUN: begin
                if (rd_en_s && beat_term_s) next_state_s = DRAIN;
                else                        next_state_s = RUN;
            end
            DRAIN: begin
                if (drain_term_s) next_state_s = CAPT;
                else              next_state_s = DRAIN;
            end
            CAPT: begin
                if (cap_s && tile_term_s) next_state_s = DONE;
                else if (cap_s)           next_state_s = RUN;
                else                      next_state_s = CAPT;
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    sa_op_counter #(.W(CKW)) u_beat (
        .clk(clk), .rstn(rstn), .load(beat_load_s), .load_val({CKW{1'b0}}),
        .en(rd_en_s), .cmp(k_r - K_ONE), .term(beat_term_s), .at_zero(beat_zero_s)
    );

    sa_op_counter #(.W(CDW)) u_drain (
        .clk(clk), .rstn(rstn), .load(drain_load_s), .load_val({CDW{1'b0}}),
        .en(state_r == DRAIN), .cmp(D_LAST), .term(drain_term_s), .at_zero(drain_zero_s)
    );

    sa_op_counter #(.W(CTW)) u_tile (
        .clk(clk), .rstn(rstn), .load(start_ok_s), .load_val({CTW{1'b0}}),
        .en(cap_s), .cmp(tiles_r - T_ONE), .term(tile_term_s), .at_zero(tile_zero_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_r <= IDLE;
        else       state_r <= next_state_s;
    end

    // Run configuration, captured only on an accepted start.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            k_r     <= {CKW{1'b0}};
            tiles_r <= {CTW{1'b0}};
        end else if (start_ok_s) begin
            k_r     <= cfg_k;
            tiles_r <= cfg_tiles;
        end else begin
            k_r     <= k_r;
            tiles_r <= tiles_r;
        end
    end

    // Saturating stall counter, cleared by each accepted start.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_r <= 32'd0;
        end else if (start_ok_s) begin
            stall_r <= 32'd0;
        end else if ((state_r == RUN) && !rd_en_s && (stall_r != 32'hFFFF_FFFF)) begin
            stall_r <= stall_r + 32'd1;
        end else begin
            stall_r <= stall_r;
        end
    end

    // Array controls trail the pop by one cycle to match the FIFO read latency.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fire_r    <= 1'b0;
            zero_in_r <= 1'b0;
            acc_clr_r <= 1'b0;
            capture_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            fire_r    <= rd_en_s || (state_r == DRAIN);
            zero_in_r <= (state_r == DRAIN);
            acc_clr_r <= rd_en_s && beat_zero_s;
            capture_r <= cap_s;
            busy_r    <= (next_state_s != IDLE);
            done_r    <= (state_r == DONE);
            err_r     <= err_s;
        end
    end

    assign rd_en     = rd_en_s;
    assign fire      = fire_r;
    assign zero_in   = zero_in_r;
    assign acc_clr   = acc_clr_r;
    assign capture   = capture_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign stall_cnt = stall_r;

endmodule

// File: tb/tb_sa_core_seq.sv
// tb_sa_core_seq: self-checking bench for sa_core_seq (8x8 array, MAXK=256, PE_LAT=1).
// Expected per-cycle outputs come from a timeline model built from the input patterns.
module tb_sa_core_seq;

    localparam int D = 8 + 8 - 2 + 1;
    localparam int N = 4096;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  cfg_k = 9'd0;
    logic [10:0] cfg_tiles = 11'd0;
    logic [7:0]  a_empty = 8'h00;
    logic [7:0]  w_empty = 8'h00;
    logic [7:0]  out_full = 8'h00;
    logic        rd_en, fire, zero_in, acc_clr, capture, busy, done, err;
    logic [31:0] stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] ae [N];
    logic [7:0] we [N];
    logic [7:0] of [N];
    logic [7:0] expv [N];
    int         t_done;
    int         exp_stall;

    sa_core_seq dut (
        .clk(clk), .rstn(rstn), .start(start), .cfg_k(cfg_k), .cfg_tiles(cfg_tiles),
        .a_empty(a_empty), .w_empty(w_empty), .out_full(out_full),
        .rd_en(rd_en), .fire(fire), .zero_in(zero_in), .acc_clr(acc_clr),
        .capture(capture), .busy(busy), .done(done), .err(err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // {rd_en, fire, zero_in, acc_clr, capture, busy, done, err}
    function automatic logic [7:0] obs_vec();
        return {rd_en, fire, zero_in, acc_clr, capture, busy, done, err};
    endfunction

    task automatic check8(input string tag, input logic [7:0] o, input logic [7:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b (rd,fire,zero,acc,cap,busy,done,err)", tag, o, e);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    task automatic clear_pat();
        for (int c = 0; c < N; c++) begin
            ae[c] = 8'h00; we[c] = 8'h00; of[c] = 8'h00;
        end
    endtask

    task automatic rand_pat();
        int lane;
        for (int c = 0; c < N; c++) begin
            ae[c] = 8'h00; we[c] = 8'h00;
            if ($urandom_range(0, 3) == 0) begin
                lane = $urandom_range(0, 15);
                if (lane < 8) ae[c] = 8'(1 << lane);
                else          we[c] = 8'(1 << (lane - 8));
            end
            of[c] = ($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
        end
    endtask

    // Timeline of a run started in cycle 0: k pops per tile (one per cycle with all
    // FIFOs non-empty), D zero-fed fires, capture once out_full is clear, then done.
    task automatic build_model(input int k, input int tiles);
        int t, beat;
        for (int c = 0; c < N; c++) expv[c] = 8'h00;
        t = 1;
        exp_stall = 0;
        for (int tl = 0; tl < tiles; tl++) begin
            beat = 0;
            while (beat < k && t < N - 64) begin
                if (ae[t] == 8'h00 && we[t] == 8'h00) begin
                    expv[t][7]   = 1'b1;
                    expv[t+1][6] = 1'b1;
                    if (beat == 0) expv[t+1][4] = 1'b1;
                    beat++;
                end else begin
                    exp_stall++;
                end
                t++;
            end
            for (int i = 1; i <= D; i++) begin
                expv[t+i][6] = 1'b1;
                expv[t+i][5] = 1'b1;
            end
            t += D;
            while (of[t] != 8'h00 && t < N - 64) t++;
            expv[t+1][3] = 1'b1;
            t++;
        end
        t_done = t;
        expv[t+1][1] = 1'b1;
        for (int c = 1; c <= t; c++) expv[c][2] = 1'b1;
    endtask

    // bad_mode: 0 none, 1 extra start while busy, 2 extra start in the DONE cycle.
    task automatic do_run(input string tag, input int k, input int tiles, input int bad_mode);
        int bad_at, rd_seen;
        build_model(k, tiles);
        bad_at = -1;
        if (bad_mode == 1)      bad_at = $urandom_range(1, t_done - 1);
        else if (bad_mode == 2) bad_at = t_done;
        if (bad_at >= 1 && bad_at < t_done) expv[bad_at+1][0] = 1'b1;
        rd_seen = 0;
        for (int c = 0; c <= t_done + 3; c++) begin
            @(posedge clk);
            #1;
            start     = (c == 0) || (c == bad_at);
            cfg_k     = (c == 0) ? 9'(k) : 9'($urandom_range(0, 511));
            cfg_tiles = (c == 0) ? 11'(tiles) : 11'($urandom_range(0, 2047));
            a_empty   = ae[c];
            w_empty   = we[c];
            out_full  = of[c];
            #1;
            if (rd_en === 1'b1) rd_seen++;
            if (c >= 1) check8($sformatf("%s_cyc%0d", tag, c), obs_vec(), expv[c]);
        end
        start = 1'b0;
        check32({tag, "_stall"}, stall_cnt, 32'(exp_stall));
        check32({tag, "_pops"}, 32'(rd_seen), 32'(k * tiles));
    endtask

    task automatic bad_idle(input string tag, input int k, input int tiles);
        @(posedge clk);
        #1;
        start = 1'b1; cfg_k = 9'(k); cfg_tiles = 11'(tiles);
        @(posedge clk);
        #1;
        start = 1'b0;
        #1;
        check8({tag, "_err"}, obs_vec(), 8'h01);
        @(posedge clk);
        #2;
        check8({tag, "_after"}, obs_vec(), 8'h00);
    endtask

    initial begin
        int nz;

        repeat (3) @(posedge clk);
        #2;
        check8("reset_outputs", obs_vec(), 8'h00);
        check32("reset_stall", stall_cnt, 32'd0);
        rstn = 1'b1;

        clear_pat();
        do_run("k4t1", 4, 1, 0);

        clear_pat();
        for (int c = 2; c <= 4; c++) ae[c] = 8'h20;
        do_run("k3t2_gap", 3, 2, 0);

        clear_pat();
        for (int c = 20; c <= 29; c++) of[c] = 8'h80;
        do_run("ofull_hold", 4, 1, 0);

        bad_idle("idle_k0", 0, 1);
        bad_idle("idle_k257", 257, 1);
        bad_idle("idle_t0", 4, 0);
        bad_idle("idle_t1025", 4, 1025);

        clear_pat();
        do_run("start_busy", 5, 2, 1);
        clear_pat();
        do_run("start_done", 2, 1, 2);

        // Abort a run in the middle of the drain.
        @(posedge clk);
        #1;
        start = 1'b1; cfg_k = 9'd4; cfg_tiles = 11'd1;
        a_empty = 8'h00; w_empty = 8'h00; out_full = 8'h00;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        check8("pre_abort_drain", obs_vec(), 8'b0110_0100);
        rstn = 1'b0;
        #1;
        check8("abort_async", obs_vec(), 8'h00);
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b1;
        nz = 0;
        repeat (25) begin
            @(posedge clk);
            #2;
            if (obs_vec() !== 8'h00) nz++;
        end
        check32("abort_quiet", 32'(nz), 32'd0);
        clear_pat();
        do_run("k2_after_abort", 2, 1, 0);

        clear_pat();
        do_run("maxk", 256, 1, 0);

        for (int r = 0; r < 6; r++) begin
            rand_pat();
            do_run($sformatf("rand%0d", r), $urandom_range(1, 12), $urandom_range(1, 3),
                   $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
